// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD text writer: FSM states, HD44780 command words, special characters.
package lcd_pkg;

  typedef enum logic [2:0] {
    WAIT_INIT,
    IDLE,
    ISSUE,
    ACK,
    HOLD
  } state_t;

  localparam logic [9:0] CMD_CLEAR    = 10'h001;
  localparam logic [9:0] CMD_DDRAM_L0 = 10'h080;
  localparam logic [9:0] CMD_DDRAM_L1 = 10'h0C0;
  localparam logic [7:0] CH_LF        = 8'h0A;
  localparam logic [7:0] CH_FF        = 8'h0C;
  localparam logic [1:0] RS_DATA      = 2'b10;

  function automatic logic [9:0] ddram_word(input logic line, input logic [3:0] col);
    return (line ? CMD_DDRAM_L1 : CMD_DDRAM_L0) | {6'd0, col};
  endfunction

endpackage

// File: rtl/lcd_char_fifo.sv
// Character FIFO for the LCD text writer: DEPTH entries of 8 bits, first-word-fall-through read, occupancy output.
module lcd_char_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/lcd_text_writer.sv
// Turns a byte stream into paced HD44780 write strobes with 2x16 cursor tracking.
// Build option LCD_FF_CLEAR_EN: form feed (0x0C) issues a display clear instead of a character write.
module lcd_text_writer
  import lcd_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int HOLDOFF = 1010,
  parameter int ACK_TO  = 16,
  parameter int COLS    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [7:0]               in_char,
  output logic                     in_ready,
  input  logic                     lcd_busy,
  output logic                     lcd_enable,
  output logic [9:0]               lcd_bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic [4:0]               cursor,
  output logic                     ack_err
);

  localparam int             TW          = $clog2(4*HOLDOFF+1);
  localparam logic [TW-1:0]  TMR_ONE     = TW'(1);
  localparam logic [TW-1:0]  ACK_LD      = TW'(ACK_TO-1);
  localparam logic [TW-1:0]  HOLD_LD     = TW'(HOLDOFF-1);
  localparam logic [TW-1:0]  HOLD_CLR_LD = TW'(4*HOLDOFF-1);
  localparam logic [3:0]     COL_LAST    = 4'(COLS-1);

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [9:0]    word_q, word_d;
  logic          line_q, line_d;
  logic [3:0]    col_q, col_d;
  logic          addr_pend_q, addr_pend_d;
  logic          low_seen_q, low_seen_d;
  logic          slow_q, slow_d;
  logic          en_d;
  logic [9:0]    bus_d;
  logic          ack_err_d;
  logic          pop;
  logic [7:0]    head;
  logic          full;
  logic          empty;

  lcd_char_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .din   (in_char),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign in_ready = !full;
  assign cursor   = {line_q, col_q};

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    word_d      = word_q;
    line_d      = line_q;
    col_d       = col_q;
    addr_pend_d = addr_pend_q;
    low_seen_d  = low_seen_q;
    slow_d      = slow_q;
    en_d        = 1'b0;
    bus_d       = '0;
    ack_err_d   = ack_err;
    pop         = 1'b0;
    case (state_q)
      WAIT_INIT: begin
        if (lcd_busy)        low_seen_d = 1'b0;
        else if (low_seen_q) state_d    = IDLE;
        else                 low_seen_d = 1'b1;
      end
      IDLE: begin
        if (addr_pend_q || !empty) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = ACK;
        tmr_d   = ACK_LD;
        en_d    = 1'b1;
        slow_d  = 1'b0;
        if (addr_pend_q) begin
          word_d      = ddram_word(line_q, col_q);
          addr_pend_d = 1'b0;
        end else begin
          pop = 1'b1;
          // Newline only moves the cursor; the address command that follows does the real work.
          if (head == CH_LF) begin
            en_d        = 1'b0;
            state_d     = IDLE;
            col_d       = '0;
            line_d      = !line_q;
            addr_pend_d = 1'b1;
          end
`ifdef LCD_FF_CLEAR_EN
          else if (head == CH_FF) begin
            word_d      = CMD_CLEAR;
            col_d       = '0;
            line_d      = 1'b0;
            addr_pend_d = 1'b0;
            slow_d      = 1'b1;
          end
`endif
          else begin
            word_d = {RS_DATA, head};
            if (col_q == COL_LAST) begin
              col_d       = '0;
              line_d      = !line_q;
              addr_pend_d = 1'b1;
            end else begin
              col_d = col_q + 4'd1;
            end
          end
        end
        bus_d = en_d ? word_d : '0;
      end
      ACK: begin
        if (lcd_busy) begin
          state_d = HOLD;
          tmr_d   = slow_q ? HOLD_CLR_LD : HOLD_LD;
        end else if (tmr_q == '0) begin
          // Reissue from the held word; the FIFO and cursor were already advanced once.
          ack_err_d = 1'b1;
          en_d      = 1'b1;
          bus_d     = word_q;
          tmr_d     = ACK_LD;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      HOLD: begin
        if (tmr_q == '0) state_d = IDLE;
        else             tmr_d   = tmr_q - TMR_ONE;
      end
      default: state_d = WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WAIT_INIT;
      tmr_q       <= '0;
      word_q      <= '0;
      line_q      <= 1'b0;
      col_q       <= '0;
      addr_pend_q <= 1'b0;
      low_seen_q  <= 1'b0;
      slow_q      <= 1'b0;
      lcd_enable  <= 1'b0;
      lcd_bus     <= '0;
      ack_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      word_q      <= word_d;
      line_q      <= line_d;
      col_q       <= col_d;
      addr_pend_q <= addr_pend_d;
      low_seen_q  <= low_seen_d;
      slow_q      <= slow_d;
      lcd_enable  <= en_d;
      lcd_bus     <= bus_d;
      ack_err     <= ack_err_d;
    end
  end

endmodule

// File: tb/tb_lcd_text_writer.sv
// Scoreboard bench for lcd_text_writer: expected strobe words are queued at stimulus time, a monitor checks each strobe.
module tb_lcd_text_writer;

  localparam int DEPTH   = 8;
  localparam int HOLDOFF = 1010;
  localparam int ACK_TO  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_char = 8'h00;
  logic       in_ready;
  logic       lcd_busy;
  logic       lcd_enable;
  logic [9:0] lcd_bus;
  logic [3:0] level;
  logic [4:0] cursor;
  logic       ack_err;

  always #5 clk = ~clk;

  lcd_text_writer #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF), .ACK_TO(ACK_TO), .COLS(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_char    (in_char),
    .in_ready   (in_ready),
    .lcd_busy   (lcd_busy),
    .lcd_enable (lcd_enable),
    .lcd_bus    (lcd_bus),
    .level      (level),
    .cursor     (cursor),
    .ack_err    (ack_err)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         strobes = 0;
  int         last_strobe = 0;
  int         prev_strobe = 0;
  logic [9:0] sb_q[$];
  logic [9:0] last_word = '0;
  bit         ack_on = 1'b1;
  bit         force_busy = 1'b1;
  bit         allow_rep = 1'b0;
  bit         busy_pend = 1'b0;
  int         busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Controller model: busy rises one cycle after a strobe and stays up a few cycles.
  initial begin
    lcd_busy = 1'b1;
    forever begin
      @(negedge clk);
      if (busy_cnt > 0) busy_cnt--;
      if (busy_pend) begin
        busy_cnt  = 4;
        busy_pend = 1'b0;
      end
      if (lcd_enable && ack_on) busy_pend = 1'b1;
      lcd_busy = force_busy || (busy_cnt != 0);
    end
  end

  // Monitor: every strobe pops one expected word; idle bus must be zero.
  initial begin
    logic [9:0] exp_w;
    forever begin
      @(negedge clk);
      if (lcd_enable) begin
        strobes++;
        prev_strobe = last_strobe;
        last_strobe = cyc;
        if (allow_rep && lcd_bus == last_word) begin
        end else if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe actual=%0h required=none", lcd_bus);
        end else begin
          exp_w = sb_q.pop_front();
          check("strobe_bus", {22'd0, lcd_bus}, {22'd0, exp_w});
        end
        last_word = lcd_bus;
      end else if (lcd_bus !== 10'h000) begin
        checks++;
        errors++;
        $display("FAIL idle_bus actual=%0h required=0", lcd_bus);
      end
    end
  end

  initial begin
    wait (cyc >= 95000);
    $display("FAIL watchdog actual=%0d cycles required=<95000", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic [7:0] c, input logic [9:0] exp_w);
    int n;
    n = 0;
    while (!in_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout actual=in_ready0 required=in_ready1");
    end else begin
      in_valid = 1'b1;
      in_char  = c;
      sb_q.push_back(exp_w);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic push_nowrite(input logic [7:0] c);
    in_valid = 1'b1;
    in_char  = c;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb_q.size());
    end
    repeat (HOLDOFF + 20) @(negedge clk);
  endtask

  task automatic wait_strobes(input int target);
    int n;
    n = 0;
    while (strobes < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (strobes < target) begin
      checks++;
      errors++;
      $display("FAIL strobe_wait actual=%0d required=%0d", strobes, target);
    end
  endtask

  initial begin
    int busy_low;
    int s0;
    int accepted;
    logic [7:0] ch;

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_level", level, 0);
    check("rst_cursor", cursor, 0);
    check("rst_enable", lcd_enable, 0);
    check("rst_bus", lcd_bus, 0);
    check("rst_ack_err", ack_err, 0);
    rst_n = 1'b1;

    // Characters queued while the controller is still busy powering up.
    push(8'h41, 10'h241);
    push(8'h42, 10'h242);
    repeat (195) @(negedge clk);
    check("no_strobe_while_busy", strobes, 0);
    check("level_while_busy", level, 2);
    force_busy = 1'b0;
    busy_low = cyc;
    drain();
    check("first_strobe_after_busy_low", (prev_strobe >= busy_low + 2), 1);
    check("strobe_gap_holdoff", (last_strobe - prev_strobe >= HOLDOFF + 2), 1);
    check("cursor_after_ab", cursor, 5'h02);

    // Newline at line 0 column 3.
    push(8'h43, 10'h243);
    push(8'h0A, 10'h0C0);
    drain();
    check("cursor_after_lf", cursor, 5'h10);
    push(8'h0A, 10'h080);
    drain();
    check("cursor_after_lf2", cursor, 5'h00);

    // 17 characters: wrap to line 1 after the 16th.
    for (int i = 0; i < 16; i++) begin
      ch = 8'h61 + 8'(i);
      push(ch, {2'b10, ch});
    end
    sb_q.push_back(10'h0C0);
    push(8'h71, 10'h271);
    drain();
    check("cursor_after_wrap", cursor, 5'h11);

    // Missing acknowledge: same word reissued after ACK_TO, FIFO popped once.
    ack_on = 1'b0;
    s0 = strobes;
    push(8'h5A, 10'h25A);
    sb_q.push_back(10'h25A);
    push(8'h59, 10'h259);
    wait_strobes(s0 + 1);
    check("level_after_first_issue", level, 1);
    check("ack_err_before_timeout", ack_err, 0);
    repeat (4) @(negedge clk);
    ack_on = 1'b1;
    wait_strobes(s0 + 2);
    check("ack_err_after_timeout", ack_err, 1);
    check("level_after_reissue", level, 1);
    check("reissue_gap", last_strobe - prev_strobe, ACK_TO);
    drain();
    check("cursor_after_timeout", cursor, 5'h13);

    // Fill past capacity while the controller never acknowledges.
    ack_on = 1'b0;
    allow_rep = 1'b1;
    accepted = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      ch = 8'h30 + 8'(i);
      in_valid = 1'b1;
      in_char  = ch;
      if (in_ready) begin
        accepted++;
        sb_q.push_back({2'b10, ch});
      end
      @(negedge clk);
    end
    check("fill_accepted", accepted, DEPTH + 1);
    check("fill_level", level, DEPTH);
    check("fill_in_ready", in_ready, 0);
    in_char = 8'h58;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("fill_no_overflow", level, DEPTH);
    ack_on = 1'b1;
    drain();
    allow_rep = 1'b0;
    check("cursor_after_fill", cursor, 5'h1C);

`ifdef LCD_FF_CLEAR_EN
    push(8'h0C, 10'h001);
    drain();
    check("cursor_after_ff", cursor, 5'h00);
`else
    push(8'h0C, 10'h20C);
    drain();
    check("cursor_after_ff", cursor, 5'h1D);
`endif

    // Reset with a character pending clears everything, including the sticky error.
    ack_on = 1'b0;
    push_nowrite(8'h4D);
    push_nowrite(8'h4E);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst2_level", level, 0);
    check("rst2_cursor", cursor, 0);
    check("rst2_ack_err", ack_err, 0);
    check("rst2_in_ready", in_ready, 1);
    check("rst2_enable", lcd_enable, 0);
    sb_q.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
